xbus_interconnect: RTL and testbench
====================================

XBUS_INTERCONNECT -- requirements
Module: xbus_interconnect

Interface
REQ-001 Parameter NMASTERS, default 2: number of xbus masters, range 1..4.
REQ-002 Parameter NSLAVES, default 4: number of xbus slaves, range 1..8.
REQ-003 Parameter SLAVE_BASE, default {32'h3000,32'h2000,32'h1000,32'h0000} packed NSLAVES*32: slave base addresses, slave i at bits [32i+31:32i].
REQ-004 Parameter SLAVE_MASK, default {4{32'hFFFF_F000}} packed NSLAVES*32: slave i hit when (addr & mask_i) == base_i.
REQ-005 Parameter TIMEOUT, default 15: maximum BUSY cycles without slave ready before error, range 1..255.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 m_as  in  NMASTERS  per-master access strobe, held until m_ready.
REQ-009 m_we  in  NMASTERS  per-master write enable.
REQ-010 m_be  in  NMASTERS*4  per-master byte enables.
REQ-011 m_addr, m_wdata  in  NMASTERS*32 each  per-master address, write data.
REQ-012 m_rdata  out  NMASTERS*32  per-master read data.
REQ-013 m_ready  out  NMASTERS  one-cycle completion pulse per master.
REQ-014 m_err  out  NMASTERS  bus error, valid only with m_ready.
REQ-015 s_cs  out  NSLAVES  one-hot slave select.
REQ-016 s_we, s_be, s_addr, s_wdata  out  1/4/32/32  shared slave controls from granted master.
REQ-017 s_rdata  in  NSLAVES*32  per-slave read data; s_ready  in  NSLAVES  per-slave completion.

Function
REQ-018 FSM states SHALL be IDLE and BUSY only.
REQ-019 In IDLE, if any m_as is high, the round-robin arbiter SHALL grant one master at the clock edge, latching its we/be/addr/wdata into the command register and entering BUSY.
REQ-020 Round-robin SHALL search from pointer ptr upward with wrap; on every completion ptr becomes (granted index + 1) mod NMASTERS.
REQ-021 Decode SHALL occur on the latched address; multiple hits resolve to the lowest slave index.
REQ-022 In BUSY with a hit, s_cs SHALL be one-hot at the hit slave and s_we/s_be/s_addr/s_wdata SHALL equal the latched command; s_cs SHALL be all-zero in IDLE.
REQ-023 In BUSY, when s_ready of the selected slave is high, m_ready[g]=1, m_err[g]=0, m_rdata[g]=selected s_rdata (0 on writes) combinationally that cycle, and the FSM SHALL return to IDLE.
REQ-024 Minimum latency: m_as sampled at edge N, m_ready at cycle N+1 if slave ready is combinational.
REQ-025 Decode miss: first BUSY cycle SHALL assert m_ready[g]=1, m_err[g]=1, m_rdata[g]=0, s_cs=0, then IDLE.
REQ-026 Wait counter (8 bits) SHALL clear on entry to BUSY and increment per BUSY cycle without ready; at count==TIMEOUT-1 without ready, respond with m_err=1, rdata 0, return IDLE, deassert s_cs.
REQ-027 Ready and timeout in the same cycle: ready wins, no error.
REQ-028 Deasserting m_as[g] while BUSY SHALL NOT abort the transfer.
REQ-029 Ungranted masters SHALL see m_ready=0, m_err=0, m_rdata=0.
REQ-030 One IDLE cycle SHALL separate consecutive transfers; requests arriving in BUSY wait.

Reset
REQ-031 rst high SHALL force IDLE, ptr=0, counter=0, command register=0 immediately, regardless of clock.
REQ-032 During and after reset until a grant: s_cs=0, s_we=0, s_be=0, s_addr=0, s_wdata=0, m_ready=0, m_err=0, m_rdata=0.
REQ-033 Reset mid-BUSY SHALL discard the transfer without m_ready.

Structure
REQ-034 State encodings, xbus widths (address/data 32, be 4) and default address map SHALL be in shared header xbus_defs.vh, replacing per-file `NSLAVES definitions.
REQ-035 Arbitration SHALL be sub-module xbus_rr_arbiter (parameter N; inputs req, ptr; output one-hot grant, grant index).

Verification
REQ-036 Master0 read 0x1004, slave1 ready same cycle with rdata 0xDEADBEEF -> m_ready[0] one cycle after request, m_rdata=0xDEADBEEF, m_err=0.
REQ-037 Both masters request continuously -> grants alternate 0,1,0,1 over four transfers, separated by one IDLE cycle.
REQ-038 Master1 write 0x2008 wdata 0x12345678 be 4'b0011 -> s_cs=4'b0100, s_addr=0x2008, s_be=4'b0011 until s_ready.
REQ-039 Access 0x9000 (no hit) -> m_err=1, m_ready=1 in first BUSY cycle, s_cs never asserted.
REQ-040 Slave2 never ready, TIMEOUT=15 -> m_ready+m_err on 15th BUSY cycle; rst pulse mid-wait in second run -> no m_ready, s_cs=0 immediately.

Source files
------------

// File: rtl/xbus_interconnect_pkg.sv
// Shared xbus widths, FSM encoding and the default slave address map.
package xbus_interconnect_pkg;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  localparam logic [127:0] DEF_BASE =
    {32'h3000, 32'h2000, 32'h1000, 32'h0000};
  localparam logic [127:0] DEF_MASK =
    {4{32'hFFFF_F000}};

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;
endpackage

// File: rtl/xbus_interconnect_if.sv
// Bundled master and slave side signals of the xbus interconnect.
interface xbus_interconnect_if #(
  parameter int NM = 2,
  parameter int NS = 4
);
  import xbus_interconnect_pkg::*;

  logic [NM-1:0]    m_as;
  logic [NM-1:0]    m_we;
  logic [NM*BW-1:0] m_be;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM*DW-1:0] m_rdata;
  logic [NM-1:0]    m_ready;
  logic [NM-1:0]    m_err;

  logic [NS-1:0]    s_cs;
  logic             s_we;
  logic [BW-1:0]    s_be;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [NS*DW-1:0] s_rdata;
  logic [NS-1:0]    s_ready;

  modport master (
    input  m_as, m_we, m_be, m_addr, m_wdata,
    output m_rdata, m_ready, m_err
  );

  modport slave (
    output s_cs, s_we, s_be, s_addr, s_wdata,
    input  s_rdata, s_ready
  );
endinterface

// File: rtl/xbus_interconnect_arbiter.sv
// Round-robin request picker: first requester at or above ptr, wrapping.
module xbus_rr_arbiter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] &&
            i == (int'(ptr) + k) % N) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          idx      = W'(i);
        end
      end
    end
  end
endmodule

// File: rtl/xbus_interconnect.sv
// Multi-master xbus interconnect: round-robin grant, address decode,
// slave wait timeout and error response on decode miss.
module xbus_interconnect
  import xbus_interconnect_pkg::*;
#(
  parameter int NMASTERS = 2,
  parameter int NSLAVES  = 4,
  parameter logic [NSLAVES*32-1:0] SLAVE_BASE = DEF_BASE,
  parameter logic [NSLAVES*32-1:0] SLAVE_MASK = DEF_MASK,
  parameter int TIMEOUT  = 15
) (
  input logic clk,
  input logic rst,
  xbus_interconnect_if.master m,
  xbus_interconnect_if.slave  s
);
  localparam int IW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;

  state_t               state;
  cmd_t                 cmd;
  cmd_t                 nxt;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        gidx;
  logic [IW-1:0]        arb_idx;
  logic [NMASTERS-1:0]  arb_grant;
  logic [7:0]           cnt;

  logic                 hit;
  logic                 hit_rdy;
  logic [DW-1:0]        hit_data;
  logic [NSLAVES-1:0]   hit_cs;
  logic                 busy;
  logic                 sel_rdy;
  logic                 tmo;
  logic                 done;
  logic                 err;
  logic [DW-1:0]        rdata;

  xbus_rr_arbiter #(.N(NMASTERS), .W(IW)) u_arb (
    .req   (m.m_as),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    nxt = '0;
    for (int i = 0; i < NMASTERS; i++) begin
      if (arb_grant[i]) begin
        nxt.we    = m.m_we[i];
        nxt.be    = m.m_be[BW*i +: BW];
        nxt.addr  = m.m_addr[AW*i +: AW];
        nxt.wdata = m.m_wdata[DW*i +: DW];
      end
    end
  end

  // Descending scan so the lowest matching slave is the last one kept.
  always_comb begin
    hit      = 1'b0;
    hit_rdy  = 1'b0;
    hit_data = '0;
    hit_cs   = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((cmd.addr & SLAVE_MASK[32*i +: 32]) ==
          SLAVE_BASE[32*i +: 32]) begin
        hit       = 1'b1;
        hit_rdy   = s.s_ready[i];
        hit_data  = s.s_rdata[DW*i +: DW];
        hit_cs    = '0;
        hit_cs[i] = 1'b1;
      end
    end
  end

  assign busy    = (state == BUSY);
  assign sel_rdy = hit && hit_rdy;
  assign tmo     = (cnt == 8'(TIMEOUT - 1));
  assign done    = busy && (!hit || sel_rdy || tmo);
  assign err     = !sel_rdy;
  assign rdata   = (sel_rdy && !cmd.we) ? hit_data : '0;

  assign s.s_cs    = (busy && hit) ? hit_cs : '0;
  assign s.s_we    = cmd.we;
  assign s.s_be    = cmd.be;
  assign s.s_addr  = cmd.addr;
  assign s.s_wdata = cmd.wdata;

  always_comb begin
    m.m_ready = '0;
    m.m_err   = '0;
    m.m_rdata = '0;
    for (int i = 0; i < NMASTERS; i++) begin
      if (done && gidx == IW'(i)) begin
        m.m_ready[i]           = 1'b1;
        m.m_err[i]             = err;
        m.m_rdata[DW*i +: DW]  = rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cmd   <= '0;
      ptr   <= '0;
      gidx  <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|m.m_as) begin
            state <= BUSY;
            cmd   <= nxt;
            gidx  <= arb_idx;
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (done) begin
            state <= IDLE;
            ptr   <= (gidx == IW'(NMASTERS - 1)) ?
                     '0 : gidx + 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_xbus_interconnect.sv
// Directed and randomized checks of the xbus interconnect against
// a transaction-level model of decode, latency, timeout and round-robin.
module tb_xbus_interconnect;
  localparam int NM = 2;
  localparam int NS = 4;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xbus_interconnect_if #(.NM(NM), .NS(NS)) bus ();

  xbus_interconnect #(
    .NMASTERS (NM),
    .NSLAVES  (NS),
    .TIMEOUT  (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .m   (bus),
    .s   (bus)
  );

  logic [31:0] sl_data [NS];
  int lat_cfg = 0;
  int lat_cnt = 0;
  int n_chk   = 0;
  int n_fail  = 0;
  int ptr_m   = 0;

  for (genvar i = 0; i < NS; i++) begin : g_sl
    assign bus.s_rdata[32*i +: 32] = sl_data[i];
  end

  // Slave model: ready once the select has been held lat_cfg cycles.
  assign bus.s_ready = (lat_cnt >= lat_cfg) ? bus.s_cs : '0;
  always_ff @(posedge clk)
    lat_cnt <= (bus.s_cs != '0) ? lat_cnt + 1 : 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int dec(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & 32'hFFFF_F000) == 32'(i) * 32'h1000) return i;
    return -1;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_cs"}, 32'(bus.s_cs), 0);
    chk({tag, "_rdy"}, 32'(bus.m_ready), 0);
    chk({tag, "_err"}, 32'(bus.m_err), 0);
    chk({tag, "_rd0"}, bus.m_rdata[31:0], 0);
    chk({tag, "_rd1"}, bus.m_rdata[63:32], 0);
  endtask

  task automatic drive(input int mi, input bit we,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [3:0] be);
    bus.m_as[mi]             = 1'b1;
    bus.m_we[mi]             = we;
    bus.m_be[4*mi +: 4]      = be;
    bus.m_addr[32*mi +: 32]  = a;
    bus.m_wdata[32*mi +: 32] = wd;
  endtask

  task automatic xfer(input int mi, input bit we,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [3:0] be,
                      input int lat);
    int  sl;
    int  dc;
    bit  er;
    bit  last;
    logic [31:0] ecs;
    sl = dec(a);
    if (sl < 0) begin
      dc = 1; er = 1'b1;
    end else if (lat + 1 <= TO) begin
      dc = lat + 1; er = 1'b0;
    end else begin
      dc = TO; er = 1'b1;
    end
    ecs = (sl >= 0) ? (32'd1 << sl) : 32'd0;
    lat_cfg = lat;
    @(negedge clk);
    drive(mi, we, a, wd, be);
    @(posedge clk);
    #1 bus.m_as = '0;
    for (int c = 1; c <= dc; c++) begin
      @(negedge clk);
      last = (c == dc);
      if (!(last && er && sl >= 0))
        chk("x_cs", 32'(bus.s_cs), ecs);
      if (sl >= 0) begin
        chk("x_addr", bus.s_addr, a);
        chk("x_be", 32'(bus.s_be), 32'(be));
        chk("x_we", 32'(bus.s_we), 32'(we));
        chk("x_wd", bus.s_wdata, wd);
      end
      chk("x_rdy", 32'(bus.m_ready),
          last ? (32'd1 << mi) : 32'd0);
      chk("x_err", 32'(bus.m_err),
          (last && er) ? (32'd1 << mi) : 32'd0);
      chk("x_rd", bus.m_rdata[32*mi +: 32],
          (last && !er && !we) ? sl_data[sl] : 32'd0);
      chk("x_rdo", bus.m_rdata[32*(1-mi) +: 32], 0);
    end
    ptr_m = (mi + 1) % NM;
    @(negedge clk);
    chk_quiet("x_idle");
  endtask

  task automatic arb(input int steps);
    int g;
    lat_cfg = 0;
    sl_data[0] = $urandom;
    @(negedge clk);
    drive(0, 1'b0, 32'h0000_0000, 0, 4'hF);
    drive(1, 1'b0, 32'h0000_0004, 0, 4'hF);
    for (int t = 0; t < steps; t++) begin
      @(negedge clk);
      if (t % 2 == 0) begin
        g = ptr_m;
        chk("arb_rdy", 32'(bus.m_ready), 32'd1 << g);
        chk("arb_rd", bus.m_rdata[32*g +: 32], sl_data[0]);
        ptr_m = (g + 1) % NM;
      end else begin
        chk_quiet("arb_idle");
      end
    end
    bus.m_as = '0;
  endtask

  initial begin
    int mi;
    int sl;
    int lat;
    bit we;
    logic [31:0] a;
    bus.m_as    = '0;
    bus.m_we    = '0;
    bus.m_be    = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    for (int i = 0; i < NS; i++) sl_data[i] = '0;

    repeat (2) @(negedge clk);
    chk_quiet("rst");
    chk("rst_we", 32'(bus.s_we), 0);
    chk("rst_be", 32'(bus.s_be), 0);
    chk("rst_addr", bus.s_addr, 0);
    chk("rst_wd", bus.s_wdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("post_rst");

    arb(8);

    sl_data[1] = 32'hDEAD_BEEF;
    xfer(0, 1'b0, 32'h1004, 0, 4'hF, 0);
    xfer(1, 1'b1, 32'h2008, 32'h1234_5678, 4'b0011, 2);
    xfer(0, 1'b0, 32'h9000, 0, 4'hF, 0);
    xfer(0, 1'b0, 32'h2000, 0, 4'hF, 100);
    sl_data[3] = 32'hA5A5_0F0F;
    xfer(1, 1'b0, 32'h3010, 0, 4'hF, TO - 1);

    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NS; i++) sl_data[i] = $urandom;
      mi = $urandom_range(0, NM - 1);
      we = 1'($urandom_range(0, 1));
      sl = $urandom_range(0, NS);
      if (sl == NS)
        a = {20'($urandom_range(4, 32'hFFFFF)), 12'($urandom)};
      else
        a = (32'(sl) << 12) | ($urandom & 32'hFFC);
      lat = ($urandom_range(0, 5) == 0) ? 20 :
            $urandom_range(0, 3);
      xfer(mi, we, a, $urandom, 4'($urandom), lat);
    end

    arb(8);

    lat_cfg = 1000;
    @(negedge clk);
    drive(0, 1'b0, 32'h2000, 0, 4'hF);
    @(posedge clk);
    #1 bus.m_as = '0;
    repeat (5) @(negedge clk);
    chk("mid_cs", 32'(bus.s_cs), 32'b0100);
    chk("mid_rdy", 32'(bus.m_ready), 0);
    rst = 1'b1;
    #1;
    chk_quiet("arst");
    repeat (2) @(negedge clk);
    chk_quiet("arst_hold");
    rst = 1'b0;
    ptr_m = 0;
    repeat (3) @(negedge clk);
    chk_quiet("arst_after");

    arb(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
